// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared types and sizing helpers for the fetch stage
package mips_fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_INCR = 32'd4;

    // Counters must hold the value QDEPTH itself, hence one bit beyond the index width.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order queue of fetched {pc, instr} entries with flush
module fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int QDEPTH = 2,
    localparam int CW = cnt_width(QDEPTH)
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  din,
    output fetch_entry_t  dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(QDEPTH);

    fetch_entry_t  mem [QDEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    assign empty = (count == '0);
    assign full  = (count == CW'(QDEPTH));
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset: dout is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - decoupled instruction fetch with credit-based issue and redirect flush
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int          QDEPTH   = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetN,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int          CW      = cnt_width(QDEPTH);
    localparam logic [CW:0] CREDITS = (CW + 1)'(QDEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   redirect_base;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] q_count;
    logic          active;
    logic          req_fire;
    logic          q_push;
    logic          q_pop;
    logic          q_full;
    logic          q_empty;
    fetch_entry_t  q_din;
    fetch_entry_t  q_dout;

    assign redirect_base = {redirect_pc[31:2], 2'b00};

    // A slot is reserved for every in-flight request, so a returning word can never overflow the queue.
    assign imem_req_valid = active && !redirect_valid &&
                            (({1'b0, q_count} + {1'b0, outstanding}) < CREDITS);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign q_push     = imem_rsp_valid && (discard == '0) && !redirect_valid;
    assign q_din      = '{pc: rsp_pc, instr: imem_rsp_data};
    assign inst_valid = !q_empty && !redirect_valid;
    assign q_pop      = inst_valid && inst_ready;
    assign inst_data  = q_dout.instr;
    assign inst_pc    = q_dout.pc;

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk    (clk),
        .resetN (resetN),
        .push   (q_push),
        .pop    (q_pop),
        .flush  (redirect_valid),
        .din    (q_din),
        .dout   (q_dout),
        .empty  (q_empty),
        .full   (q_full),
        .count  (q_count)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            active      <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            active      <= 1'b1;
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                // Every request still in flight after this cycle returns a stale word.
                fetch_pc <= redirect_base;
                rsp_pc   <= redirect_base;
                discard  <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_INCR;
                if (q_push)   rsp_pc   <= rsp_pc + PC_INCR;
                if (imem_rsp_valid && (discard != '0)) discard <= discard - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized, model-checked bench for fetch_unit
module tb_fetch_unit;
    import mips_fetch_pkg::*;

    localparam int          QD    = 2;
    localparam logic [31:0] HI_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        redirect_valid, inst_valid, inst_ready;
    logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, inst_data, inst_pc;

    logic        h_req_valid, h_req_ready, h_rsp_valid, h_redirect_valid, h_inst_valid, h_inst_ready;
    logic [31:0] h_req_addr, h_rsp_data, h_redirect_pc, h_inst_data, h_inst_pc;

    fetch_unit #(.QDEPTH(QD), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .resetN(resetN),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    fetch_unit #(.QDEPTH(4), .RESET_PC(HI_PC)) dut_hi (
        .clk(clk), .resetN(resetN),
        .imem_req_valid(h_req_valid), .imem_req_addr(h_req_addr), .imem_req_ready(h_req_ready),
        .imem_rsp_valid(h_rsp_valid), .imem_rsp_data(h_rsp_data),
        .redirect_valid(h_redirect_valid), .redirect_pc(h_redirect_pc),
        .inst_valid(h_inst_valid), .inst_data(h_inst_data), .inst_pc(h_inst_pc), .inst_ready(h_inst_ready)
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } mreq_t;

    mreq_t        pend[$];
    fetch_entry_t expq[$];
    logic [31:0]  m_fetch_pc;
    logic [31:0]  h_pend[$];

    int          cyc, n_checks, n_fail, lat_min, lat_max;
    logic [31:0] hs_addr[$], dl_pc[$], h_hs_addr[$], h_dl_pc[$];
    int          hs_cyc[$], dl_cyc[$], h_dl_cyc[$];
    logic        drv_req_ready, drv_inst_ready, drv_redirect;
    logic [31:0] drv_redirect_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        hs_addr.delete(); hs_cyc.delete(); dl_pc.delete(); dl_cyc.delete();
        h_hs_addr.delete(); h_dl_pc.delete(); h_dl_cyc.delete();
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        drv_req_ready = 0; drv_inst_ready = 0; drv_redirect = 0; drv_redirect_pc = '0;
        imem_req_ready = 0; inst_ready = 0; redirect_valid = 0; redirect_pc = '0;
        imem_rsp_valid = 0; imem_rsp_data = '0;
        h_req_ready = 0; h_inst_ready = 0; h_rsp_valid = 0; h_rsp_data = '0;
        h_redirect_valid = 0; h_redirect_pc = '0;
        pend.delete(); expq.delete(); h_pend.delete();
        m_fetch_pc = 32'h0;
        clear_logs();
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_hi_req_valid", h_req_valid, 0);
        @(negedge clk);
        resetN = 1'b1;
        cyc = 0;
    endtask

    // One cycle: drive inputs at negedge, compare against the model, then advance the model past the posedge.
    task automatic step();
        bit    exp_req, exp_inst;
        int    stale_n;
        mreq_t r;
        @(negedge clk);
        cyc++;
        imem_req_ready = drv_req_ready;
        inst_ready     = drv_inst_ready;
        redirect_valid = drv_redirect;
        redirect_pc    = drv_redirect_pc;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
        end
        h_req_ready = 1'b1; h_inst_ready = 1'b1;
        h_rsp_valid = 1'b0; h_rsp_data = '0;
        if (h_pend.size() > 0) begin
            h_rsp_valid = 1'b1;
            h_rsp_data  = mem_word(h_pend[0]);
        end
        #1;
        exp_req  = (expq.size() + pend.size() < QD) && !redirect_valid;
        exp_inst = (expq.size() > 0) && !redirect_valid;
        stale_n  = 0;
        foreach (pend[i]) if (pend[i].stale) stale_n++;
        chk("req_valid", imem_req_valid, exp_req);
        if (exp_req) chk("req_addr", imem_req_addr, m_fetch_pc);
        chk("inst_valid", inst_valid, exp_inst);
        if (exp_inst) begin
            chk("inst_pc", inst_pc, expq[0].pc);
            chk("inst_data", inst_data, expq[0].instr);
        end
        chk("outstanding", dut.outstanding, pend.size());
        chk("discard", dut.discard, stale_n);
        chk("no_overflow", dut.q_push && dut.q_full && !dut.q_pop, 0);

        if (imem_req_valid && imem_req_ready) begin hs_addr.push_back(imem_req_addr); hs_cyc.push_back(cyc); end
        if (inst_valid && inst_ready) begin dl_pc.push_back(inst_pc); dl_cyc.push_back(cyc); end

        if (exp_inst && inst_ready) void'(expq.pop_front());
        if (imem_rsp_valid) begin
            r = pend.pop_front();
            if (!r.stale && !redirect_valid) expq.push_back('{pc: r.addr, instr: mem_word(r.addr)});
        end
        if (redirect_valid) begin
            expq.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            m_fetch_pc = {redirect_pc[31:2], 2'b00};
        end else if (exp_req && imem_req_ready) begin
            pend.push_back('{addr: m_fetch_pc, stale: 1'b0, due: cyc + int'($urandom_range(lat_min, lat_max))});
            m_fetch_pc = m_fetch_pc + 32'd4;
        end

        if (h_inst_valid) begin
            h_dl_pc.push_back(h_inst_pc);
            h_dl_cyc.push_back(cyc);
            chk("hi_inst_data", h_inst_data, mem_word(h_inst_pc));
        end
        if (h_rsp_valid) void'(h_pend.pop_front());
        if (h_req_valid) begin h_pend.push_back(h_req_addr); h_hs_addr.push_back(h_req_addr); end
        drv_redirect = 1'b0;
    endtask

    logic [31:0] seq_lo [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] seq_hi [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};

    initial begin
        int  pre_out;
        bit  found;
        n_checks = 0; n_fail = 0; cyc = 0;
        lat_min = 1; lat_max = 1;

        // Zero-wait memory, decode always ready; the wide instance runs alongside from RESET_PC near the top.
        do_reset();
        drv_req_ready = 1; drv_inst_ready = 1;
        repeat (12) step();
        chk("t1_enough_hs", hs_cyc.size() >= 1, 1);
        chk("t1_enough_dl", dl_pc.size() >= 4, 1);
        if (hs_cyc.size() >= 1 && dl_pc.size() >= 4) begin
            chk("t1_first_hs_cyc", hs_cyc[0], 1);
            chk("t1_first_latency", dl_cyc[0], hs_cyc[0] + 2);
            for (int k = 0; k < 4; k++) chk("t1_pc_seq", dl_pc[k], seq_lo[k]);
        end
        chk("t6_enough", (h_hs_addr.size() >= 4) && (h_dl_pc.size() >= 4), 1);
        if (h_hs_addr.size() >= 4 && h_dl_pc.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("t6_req_wrap", h_hs_addr[k], seq_hi[k]);
                chk("t6_pc_wrap", h_dl_pc[k], seq_hi[k]);
            end
            for (int k = 0; k < 3; k++) chk("t6_back_to_back", h_dl_cyc[k + 1], h_dl_cyc[k] + 1);
        end

        // Memory not ready: request held, nothing delivered.
        do_reset();
        drv_req_ready = 0; drv_inst_ready = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t2_req_held", imem_req_valid, 1);
            chk("t2_addr_held", imem_req_addr, 32'h0);
            chk("t2_no_inst", inst_valid, 0);
        end
        drv_req_ready = 1;
        repeat (3) step();
        chk("t2_hs_after", (hs_addr.size() >= 1) ? hs_addr[0] : 32'hDEAD, 32'h0);

        // Decode stalled: exactly QDEPTH requests, then drain in order.
        do_reset();
        drv_req_ready = 1; drv_inst_ready = 0;
        repeat (6) step();
        chk("t3_hs_count", hs_addr.size(), 2);
        chk("t3_req_stopped", imem_req_valid, 0);
        drv_inst_ready = 1;
        repeat (6) step();
        chk("t3_enough", (hs_addr.size() >= 3) && (dl_pc.size() >= 2), 1);
        if (hs_addr.size() >= 3 && dl_pc.size() >= 2) begin
            chk("t3_hs0", hs_addr[0], 32'h0);
            chk("t3_hs1", hs_addr[1], 32'h4);
            chk("t3_dl0", dl_pc[0], 32'h0);
            chk("t3_dl1", dl_pc[1], 32'h4);
            chk("t3_resume", hs_addr[2], 32'h8);
        end

        // Three-cycle memory, redirect with two requests in flight.
        lat_min = 3; lat_max = 3;
        do_reset();
        drv_req_ready = 1; drv_inst_ready = 1;
        repeat (2) step();
        chk("t4_inflight", hs_addr.size(), 2);
        drv_redirect = 1; drv_redirect_pc = 32'h0000_0103;
        step();
        chk("t4_no_req_on_redirect", imem_req_valid, 0);
        clear_logs();
        step();
        chk("t4_discard", dut.discard, 2);
        repeat (12) step();
        chk("t4_next_req", (hs_addr.size() >= 1) ? hs_addr[0] : 32'hDEAD, 32'h100);
        chk("t4_first_inst", (dl_pc.size() >= 1) ? dl_pc[0] : 32'hDEAD, 32'h100);

        // Redirect coinciding with a response and a ready decode.
        lat_min = 1; lat_max = 1;
        do_reset();
        drv_req_ready = 1; drv_inst_ready = 1;
        found = 0; pre_out = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (expq.size() > 0 && pend.size() > 0 && pend[0].due <= cyc + 1) begin
                found = 1; pre_out = pend.size();
                drv_redirect = 1; drv_redirect_pc = 32'h0000_2000;
            end
            step();
        end
        step();
        chk("t5_found", found, 1);
        chk("t5_discard", dut.discard, pre_out - 1);
        chk("t5_queue_empty", inst_valid, 0);

        // Asynchronous reset while both instances are busy.
        do_reset();
        drv_req_ready = 1; drv_inst_ready = 1;
        repeat (4) step();
        chk("t6_pre_inst", inst_valid, 1);
        chk("t6_pre_req", imem_req_valid, 1);
        chk("t6_pre_hi_inst", h_inst_valid, 1);
        #2 resetN = 1'b0;
        #1;
        chk("t6_async_inst", inst_valid, 0);
        chk("t6_async_req", imem_req_valid, 0);
        chk("t6_async_hi_inst", h_inst_valid, 0);
        chk("t6_async_hi_req", h_req_valid, 0);

        // Randomized traffic with variable latency and occasional redirects.
        lat_min = 1; lat_max = 4;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            drv_req_ready  = ($urandom_range(0, 3) != 0);
            drv_inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                drv_redirect    = 1;
                drv_redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                              : 32'($urandom);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
